// File: rtl/systolic_feeder.sv
// systolic_feeder: upstream stage of an NxN output-stationary systolic array.
// Accepts one A column and one B row per valid/ready beat, applies the
// diagonal skew (lane i delayed i cycles) onto the north (input_data) and
// west (weight_data) buses, flushes zeros after K beats and then strobes
// load so the array captures its accumulators. done pulses one cycle later.
// Optional feature macro: FEEDER_STALL_CNT_EN adds a 16-bit stall_cnt output
// counting STREAM cycles with in_valid low (saturating).
module systolic_feeder #(
    parameter int N      = 9,
    parameter int DW     = 32,
    parameter int K      = 9,
    parameter int PE_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] a_vec,
    input  logic [N*DW-1:0] b_vec,
    output logic [N*DW-1:0] input_data,
    output logic [N*DW-1:0] weight_data,
    output logic            load,
    output logic            busy,
    output logic            done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);

    localparam int BCW = $clog2(K + 1);
    localparam int DCW = $clog2(2 * N + PE_LAT);

    // Last beat of a product; the beat counter compares against this.
    localparam logic [BCW-1:0] K_LAST     = BCW'(K);
    // Cycles spent in DRAIN so the final product reaches PE(N-1,N-1) and
    // settles through its accumulator register before load.
    localparam logic [DCW-1:0] DRAIN_INIT = DCW'(2 * N - 2 + PE_LAT);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_LOAD   = 2'd3;

    logic [1:0]     state_reg, state_next;
    logic [BCW-1:0] beat_reg, beat_next;
    logic [DCW-1:0] drain_reg, drain_next;
    logic           in_ready_reg, in_ready_next;
    logic           done_reg;
    logic           xfer;
    logic [BCW-1:0] beat_plus;

    // A beat moves only when the registered ready is high.
    assign xfer      = in_valid && in_ready_reg;
    assign beat_plus = beat_reg + BCW'(1);

    // Next-state logic: count beats, switch to DRAIN on the K-th beat,
    // count the flush down, then one LOAD cycle back to IDLE.
    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        drain_next = drain_reg;
        case (state_reg)
            ST_IDLE, ST_STREAM: begin
                if (xfer) begin
                    if (beat_plus == K_LAST) begin
                        state_next = ST_DRAIN;
                        beat_next  = '0;
                        drain_next = DRAIN_INIT;
                    end else begin
                        state_next = ST_STREAM;
                        beat_next  = beat_plus;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_reg == '0) begin
                    state_next = ST_LOAD;
                end else begin
                    drain_next = drain_reg - DCW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        in_ready_next = (state_next == ST_IDLE) || (state_next == ST_STREAM);
    end

    // Control registers; ready is registered so it stays low through reset
    // and rises the cycle after reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            beat_reg     <= '0;
            drain_reg    <= '0;
            in_ready_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            beat_reg     <= beat_next;
            drain_reg    <= drain_next;
            in_ready_reg <= in_ready_next;
            done_reg     <= (state_reg == ST_LOAD);
        end
    end

    assign in_ready = in_ready_reg;
    assign load     = (state_reg == ST_LOAD);
    assign busy     = (state_reg != ST_IDLE);
    assign done     = done_reg;

    // Skew pipeline: lane gi owns a capture register plus gi delay stages.
    // Cycles without a transfer inject zeros so bubbles add nothing to the
    // accumulators and the diagonal alignment is preserved.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DW-1:0] a_sr_reg [0:gi];
        logic [DW-1:0] b_sr_reg [0:gi];

        // Capture (or inject zero) then shift one stage per cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int j = 0; j <= gi; j++) begin
                    a_sr_reg[j] <= '0;
                    b_sr_reg[j] <= '0;
                end
            end else begin
                a_sr_reg[0] <= xfer ? a_vec[(N-1-gi)*DW +: DW] : '0;
                b_sr_reg[0] <= xfer ? b_vec[(N-1-gi)*DW +: DW] : '0;
                for (int j = 1; j <= gi; j++) begin
                    a_sr_reg[j] <= a_sr_reg[j-1];
                    b_sr_reg[j] <= b_sr_reg[j-1];
                end
            end
        end

        assign input_data[(N-1-gi)*DW +: DW]  = a_sr_reg[gi];
        assign weight_data[(N-1-gi)*DW +: DW] = b_sr_reg[gi];
    end

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    // Stall counter: restarts with each product, counts empty STREAM
    // cycles, saturates, and holds through DRAIN/LOAD/IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == ST_IDLE) && xfer) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == ST_STREAM) && !in_valid &&
                     (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder: two instances (K=3 and K=1, N=3) checked
// every cycle against an event-level model (injection history per edge,
// beat count, scheduled load edge), plus hand-computed spot checks.
module tb_systolic_feeder;

    localparam int N        = 3;
    localparam int DW       = 32;
    localparam int PE_LAT   = 1;
    localparam int LOAD_LAT = 2 * N - 1 + PE_LAT;
    localparam int MAXC     = 4096;
    localparam int KK0      = 3;
    localparam int KK1      = 1;

    logic clk = 1'b0;
    logic [1:0] rst_s = 2'b11;
    logic [1:0] vld_s = 2'b00;
    logic [1:0] rdy_o, load_o, busy_o, done_o;
    logic [1:0][N*DW-1:0] a_s = '0;
    logic [1:0][N*DW-1:0] b_s = '0;
    logic [1:0][N*DW-1:0] id_o, wd_o;
`ifdef FEEDER_STALL_CNT_EN
    logic [1:0][15:0] sc_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_feeder #(.N(N), .DW(DW), .K(KK0), .PE_LAT(PE_LAT)) u_k3 (
        .clk(clk), .reset(rst_s[0]), .in_valid(vld_s[0]), .in_ready(rdy_o[0]),
        .a_vec(a_s[0]), .b_vec(b_s[0]), .input_data(id_o[0]), .weight_data(wd_o[0]),
        .load(load_o[0]), .busy(busy_o[0]), .done(done_o[0])
`ifdef FEEDER_STALL_CNT_EN
        , .stall_cnt(sc_o[0])
`endif
    );

    systolic_feeder #(.N(N), .DW(DW), .K(KK1), .PE_LAT(PE_LAT)) u_k1 (
        .clk(clk), .reset(rst_s[1]), .in_valid(vld_s[1]), .in_ready(rdy_o[1]),
        .a_vec(a_s[1]), .b_vec(b_s[1]), .input_data(id_o[1]), .weight_data(wd_o[1]),
        .load(load_o[1]), .busy(busy_o[1]), .done(done_o[1])
`ifdef FEEDER_STALL_CNT_EN
        , .stall_cnt(sc_o[1])
`endif
    );

    // ---------------- behavioural model ----------------
    int       cyc = -1;
    int       kk [2];
    int       beats [2];
    int       pend [2];
    bit       rdy_m [2];
    int       stall_m [2];
    int       rst_edge [2];
    logic [DW-1:0] inj_a [2][MAXC][N];
    logic [DW-1:0] inj_b [2][MAXC][N];

    function automatic logic [DW-1:0] lane(input logic [N*DW-1:0] v, input int i);
        return v[(N-1-i)*DW +: DW];
    endfunction

    function automatic logic [N*DW-1:0] vec3(input logic [31:0] x0, input logic [31:0] x1,
                                             input logic [31:0] x2);
        return {x0, x1, x2};
    endfunction

    task automatic chk(input string name, input int u, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cycle=%0d actual=%0h expected=%0h",
                     name, u, cyc, act, exp);
        end
    endtask

    // Model update on each rising edge from the inputs seen at that edge.
    initial begin
        bit xfer;
        kk[0] = KK0;
        kk[1] = KK1;
        for (int u = 0; u < 2; u++) begin
            beats[u] = 0; pend[u] = -1; rdy_m[u] = 1'b0; stall_m[u] = 0; rst_edge[u] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int u = 0; u < 2; u++) begin
                if (rst_s[u]) begin
                    beats[u] = 0; pend[u] = -1; rdy_m[u] = 1'b0; stall_m[u] = 0;
                    rst_edge[u] = cyc;
                    xfer = 1'b0;
                end else begin
                    xfer = vld_s[u] && rdy_m[u];
                    if (beats[u] > 0 && !vld_s[u] && stall_m[u] < 65535) stall_m[u]++;
                    if (xfer && beats[u] == 0) stall_m[u] = 0;
                    if (xfer) begin
                        beats[u]++;
                        if (beats[u] == kk[u]) begin
                            beats[u] = 0;
                            pend[u]  = cyc + LOAD_LAT;
                        end
                    end
                    rdy_m[u] = !(pend[u] >= 0 && cyc <= pend[u]);
                end
                if (cyc < MAXC) begin
                    for (int i = 0; i < N; i++) begin
                        inj_a[u][cyc][i] = xfer ? lane(a_s[u], i) : '0;
                        inj_b[u][cyc][i] = xfer ? lane(b_s[u], i) : '0;
                    end
                end
            end
        end
    end

    // Compare process: every output of both instances, every cycle.
    initial begin
        logic [DW-1:0] ea, eb;
        forever begin
            @(negedge clk);
            if (cyc >= 0 && cyc < MAXC) begin
                for (int u = 0; u < 2; u++) begin
                    chk("in_ready", u, 32'(rdy_o[u]), 32'(rdy_m[u]));
                    chk("busy", u, 32'(busy_o[u]),
                        32'(beats[u] > 0 || (pend[u] >= 0 && cyc <= pend[u])));
                    chk("load", u, 32'(load_o[u]), 32'(pend[u] >= 0 && cyc == pend[u]));
                    chk("done", u, 32'(done_o[u]), 32'(pend[u] >= 0 && cyc == pend[u] + 1));
                    for (int i = 0; i < N; i++) begin
                        ea = (cyc - i > rst_edge[u]) ? inj_a[u][cyc-i][i] : '0;
                        eb = (cyc - i > rst_edge[u]) ? inj_b[u][cyc-i][i] : '0;
                        chk("input_data_lane", u, lane(id_o[u], i), ea);
                        chk("weight_data_lane", u, lane(wd_o[u], i), eb);
                    end
`ifdef FEEDER_STALL_CNT_EN
                    chk("stall_cnt", u, 32'(sc_o[u]), 32'(stall_m[u]));
`endif
                    if (pend[u] >= 0 && cyc == pend[u])
                        $display("inst %0d: product load at cycle %0d", u, cyc);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input int u, input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
        vld_s[u] = 1'b1;
        a_s[u]   = a;
        b_s[u]   = b;
        step();
        vld_s[u] = 1'b0;
        a_s[u]   = {$urandom(), $urandom(), $urandom()};
        b_s[u]   = {$urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_load(input int u, input int t_last, input string nm, output int t_load);
        bit seen;
        seen   = 1'b0;
        t_load = -1;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (load_o[u]) begin
                seen   = 1'b1;
                t_load = cyc;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_load inst=%0d actual=no load in 20 cycles expected=load", nm, u);
        end else begin
            chk({nm, "_load_latency"}, u, 32'(t_load - t_last), 32'd6);
            step();
            chk({nm, "_done_pulse"}, u, 32'(done_o[u]), 32'd1);
        end
    endtask

    logic [N*DW-1:0] ones;
    int t_last, t_l1, t_l2, t0;
    bit saw;

    initial begin
        ones = vec3(32'd1, 32'd1, 32'd1);
        // Reset, then idle.
        step(); step(); step();
        chk("reset_in_ready", 0, 32'(rdy_o[0]), 32'd0);
        chk("reset_input_data", 0, id_o[0][31:0], 32'd0);
        rst_s = 2'b00;
        step();
        chk("ready_after_release", 0, 32'(rdy_o[0]), 32'd1);
        step();

        // Three beats, no bubbles.
        beat(0, vec3(1, 2, 3), ones);
        chk("t1_lane0_beat1", 0, lane(id_o[0], 0), 32'd1);
        beat(0, vec3(4, 5, 6), ones);
        beat(0, vec3(7, 8, 9), ones);
        t_last = cyc;
        chk("t1_lane0_beat3", 0, lane(id_o[0], 0), 32'd7);
        chk("t1_lane2_beat1", 0, lane(id_o[0], 2), 32'd3);
        chk("t1_w_lane1", 0, lane(wd_o[0], 1), 32'd1);
        wait_load(0, t_last, "t1", t_l1);
        step();

        // Two bubbles after beat 1.
        beat(0, vec3(1, 2, 3), ones);
        step(); step();
        beat(0, vec3(4, 5, 6), ones);
        chk("t2_lane0_beat2", 0, lane(id_o[0], 0), 32'd4);
        beat(0, vec3(7, 8, 9), ones);
        t_last = cyc;
        wait_load(0, t_last, "t2", t_l1);
`ifdef FEEDER_STALL_CNT_EN
        chk("t2_stall_cnt", 0, 32'(sc_o[0]), 32'd2);
`endif
        step();

        // in_valid held high across DRAIN: back-to-back products.
        vld_s[0] = 1'b1;
        a_s[0]   = vec3(11, 12, 13);
        b_s[0]   = vec3(21, 22, 23);
        step();
        t0 = cyc;
        wait_load(0, t0 + 2, "t3a", t_l1);
        wait_load(0, t_l1 + 4, "t3b", t_l2);
        vld_s[0] = 1'b0;
        chk("t3_second_load_gap", 0, 32'(t_l2 - t_l1), 32'd10);
        step(); step();

        // Reset two cycles into DRAIN aborts the product.
        beat(0, vec3(1, 2, 3), ones);
        beat(0, vec3(4, 5, 6), ones);
        beat(0, vec3(7, 8, 9), ones);
        step(); step();
        rst_s[0] = 1'b1;
        step();
        chk("t4_id_zero", 0, id_o[0][95:64] | id_o[0][63:32] | id_o[0][31:0], 32'd0);
        chk("t4_wd_zero", 0, wd_o[0][95:64] | wd_o[0][63:32] | wd_o[0][31:0], 32'd0);
        chk("t4_busy", 0, 32'(busy_o[0]), 32'd0);
        rst_s[0] = 1'b0;
        saw = 1'b0;
        for (int n = 0; n < 12; n++) begin
            step();
            if (load_o[0] || done_o[0]) saw = 1'b1;
        end
        chk("t4_no_load_after_abort", 0, 32'(saw), 32'd0);
        beat(0, vec3(31, 32, 33), vec3(41, 42, 43));
        beat(0, vec3(34, 35, 36), vec3(44, 45, 46));
        beat(0, vec3(37, 38, 39), vec3(47, 48, 49));
        t_last = cyc;
        wait_load(0, t_last, "t4", t_l1);

        // K=1 instance: single beat goes straight to DRAIN.
        beat(1, vec3(5, 6, 7), vec3(8, 9, 10));
        t_last = cyc;
        chk("t5_busy", 1, 32'(busy_o[1]), 32'd1);
        chk("t5_in_ready", 1, 32'(rdy_o[1]), 32'd0);
        step();
        chk("t5_lane1", 1, lane(id_o[1], 1), 32'd6);
        wait_load(1, t_last, "t5", t_l1);

        // Randomized traffic with occasional resets on both instances.
        for (int n = 0; n < 600; n++) begin
            for (int u = 0; u < 2; u++) begin
                vld_s[u] = ($urandom_range(99) < 60);
                rst_s[u] = ($urandom_range(79) == 0);
                a_s[u]   = {$urandom(), $urandom(), $urandom()};
                b_s[u]   = {$urandom(), $urandom(), $urandom()};
            end
            step();
        end
        rst_s = 2'b00;
        vld_s = 2'b00;
        for (int n = 0; n < 25; n++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
